// File: rtl/vc_test_rand_delay_source_pkg.sv
// vc_test_rand_delay_source_pkg: shared state encodings, LFSR constants and LFSR step helper
package vc_test_rand_delay_source_pkg;

    localparam int LFSR_W = 32;
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 32'h8020_0003;
    localparam int DELAY_W = 16;

    typedef enum logic [1:0] {
        IDLE_DELAY = 2'd0,
        SEND       = 2'd1,
        FINISHED   = 2'd2
    } state_t;

    // Galois step for x^32+x^22+x^2+x+1, shifting toward bit 0
    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
        return {1'b0, s[LFSR_W-1:1]} ^ (s[0] ? LFSR_TAPS : '0);
    endfunction

endpackage

// File: rtl/vc_test_rand_delay_source_lfsr.sv
// vc_lfsr32: 32-bit Galois LFSR that steps once per asserted advance
module vc_lfsr32
    import vc_test_rand_delay_source_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [LFSR_W-1:0] seed,
    input  logic              advance,
    output logic [LFSR_W-1:0] out
);

    logic [LFSR_W-1:0] lfsr_q, lfsr_d;

    // While reset is high the seed is the current value, so a draw taken on
    // the reset edge consumes the seed and leaves its successor in the register
    always_comb begin
        out    = reset ? seed : lfsr_q;
        lfsr_d = advance ? lfsr_step(out) : out;
    end

    // State register
    always_ff @(posedge clk) begin
        lfsr_q <= lfsr_d;
    end

endmodule

// File: rtl/vc_test_rand_delay_source.sv
// vc_test_rand_delay_source: val/rdy message source from memory m[] with pseudo-random idle gaps
module vc_test_rand_delay_source
    import vc_test_rand_delay_source_pkg::*;
#(
    parameter int          p_msg_sz    = 1,
    parameter int          p_mem_sz    = 1024,
    parameter int          p_max_delay = 0,
    parameter logic [31:0] p_seed      = 32'hb9b9_b9b9
) (
    input  logic                clk,
    input  logic                reset,
    output logic                val,
    input  logic                rdy,
    output logic [p_msg_sz-1:0] msg,
    output logic                done
);

    localparam int IW = $clog2(p_mem_sz) + 1;

    logic [p_msg_sz-1:0] m [p_mem_sz];

    state_t             state_q, state_d;
    logic [IW-1:0]      index_q, index_d;
    logic [DELAY_W-1:0] count_q, count_d, delay;
    logic [LFSR_W-1:0]  lfsr;
    logic               draw;

    vc_lfsr32 u_lfsr (
        .clk     (clk),
        .reset   (reset),
        .seed    (p_seed),
        .advance (draw),
        .out     (lfsr)
    );

    // End of stream: past the last slot, or an entry never written
    function automatic logic at_end(input logic [IW-1:0] i);
        return (i >= IW'(p_mem_sz)) || $isunknown(m[i[IW-2:0]]);
    endfunction

    // Next-state logic; the reset edge itself draws the first delay and picks the first state
    always_comb begin
        state_d = state_q;
        index_d = index_q;
        count_d = count_q;
        draw    = 1'b0;
        delay   = DELAY_W'({16'b0, lfsr[DELAY_W-1:0]} % (p_max_delay + 1));
        if (reset) begin
            draw    = 1'b1;
            index_d = '0;
            count_d = delay;
            state_d = at_end('0) ? FINISHED : (delay == '0 ? SEND : IDLE_DELAY);
        end else begin
            case (state_q)
                IDLE_DELAY: begin
                    count_d = count_q - 1'b1;
                    state_d = count_q == DELAY_W'(1) ? SEND : IDLE_DELAY;
                end
                SEND: if (rdy) begin
                    draw    = 1'b1;
                    index_d = index_q + 1'b1;
                    count_d = delay;
                    state_d = at_end(index_q + 1'b1) ? FINISHED : (delay == '0 ? SEND : IDLE_DELAY);
                end
                default: ;
            endcase
        end
    end

    // Outputs depend only on state and index, never on rdy
    always_comb begin
        val  = !reset && state_q == SEND;
        done = !reset && state_q == FINISHED;
        msg  = m[index_q[IW-2:0]];
    end

    // State registers
    always_ff @(posedge clk) begin
        state_q <= state_d;
        index_q <= index_d;
        count_q <= count_d;
    end

endmodule

// File: tb/tb_vc_test_rand_delay_source.sv
// tb_vc_test_rand_delay_source: scoreboard bench with random rdy and a delay-sequence model
module tb_vc_test_rand_delay_source;

    localparam logic [31:0] SEED = 32'hb9b9_b9b9;
    localparam int N = 6;
    localparam int MAXD = 5;

    logic        clk = 1'b0, reset = 1'b1, rdy = 1'b0, val, done;
    logic [7:0]  msg;
    logic        reset0 = 1'b1, rdy0 = 1'b0, val0, done0;
    logic [12:0] msg0;
    int total = 0, bad = 0, sent = 0, idle = 0;
    bit shown = 0;

    typedef struct { logic [7:0] msg; int gap; } exp_t;
    exp_t q [$];
    logic [7:0] mem [N];

    always #5 clk = ~clk;

    vc_test_rand_delay_source #(.p_msg_sz(8), .p_mem_sz(N), .p_max_delay(MAXD), .p_seed(SEED)) dut (
        .clk(clk), .reset(reset), .val(val), .rdy(rdy), .msg(msg), .done(done)
    );

    vc_test_rand_delay_source #(.p_msg_sz(13), .p_mem_sz(4), .p_max_delay(0)) dut0 (
        .clk(clk), .reset(reset0), .val(val0), .rdy(rdy0), .msg(msg0), .done(done0)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: idle gap before message k is the k-th LFSR state's low 16 bits mod (MAXD+1)
    function automatic void load_expected();
        logic [31:0] s = SEED;
        q.delete();
        for (int k = 0; k < N; k++) begin
            q.push_back('{mem[k], int'(s[15:0]) % (MAXD + 1)});
            s = s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
        end
    endfunction

    // Monitor: compares each presented message, its preceding idle gap, and done
    always @(negedge clk) begin
        if (reset) begin
            check("rst_val", val, 0);
            check("rst_done", done, 0);
            idle = 0;
            shown = 0;
        end else if (!val) begin
            check("done", done, q.size() == 0);
            if (q.size() != 0) idle++;
        end else if (q.size() == 0) begin
            check("extra_val", val, 0);
        end else begin
            check("msg", msg, q[0].msg);
            if (!shown) check("gap", idle, q[0].gap);
            shown = 1;
            if (rdy) begin
                void'(q.pop_front());
                sent++;
                idle = 0;
                shown = 0;
            end
        end
    end

    initial begin
        for (int k = 0; k < N; k++) begin
            mem[k] = 8'($urandom);
            dut.m[k] = mem[k];
        end
        load_expected();
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        for (int c = 0; c < 500 && !done; c++) begin
            @(posedge clk);
            #1 rdy = ($urandom % 4) != 0;
        end
        check("run1_done", done, 1);
        check("run1_sent", sent, N);
        reset = 1'b1;
        load_expected();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        for (int c = 0; c < 500 && sent < N + 3; c++) begin
            @(posedge clk);
            #1 rdy = $urandom_range(0, 1);
        end
        check("mid_sent", sent, N + 3);
        reset = 1'b1;
        rdy = 1'b1;
        load_expected();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        for (int c = 0; c < 500 && !done; c++) begin
            @(posedge clk);
            #1 rdy = ($urandom % 3) != 0;
        end
        check("run3_done", done, 1);
        check("total_sent", sent, 2 * N + 3);
        repeat (3) @(posedge clk);
        #1 check("done_sticky", done, 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Back-to-back instance: rdy low for 3 cycles, then 4 transfers in a row, then done
    initial begin
        logic [12:0] m0 [4];
        m0[0] = 13'h11aa;
        m0[1] = 13'h02bb;
        m0[2] = 13'h13cc;
        m0[3] = 13'h04dd;
        for (int k = 0; k < 4; k++) dut0.m[k] = m0[k];
        repeat (3) @(posedge clk);
        #1 reset0 = 1'b0;
        for (int c = 0; c < 10; c++) begin
            rdy0 = c >= 3;
            @(negedge clk);
            check("b2b_val", val0, c < 7);
            check("b2b_done", done0, c >= 7);
            if (c < 7) check("b2b_msg", msg0, m0[c < 3 ? 0 : c - 3]);
            @(posedge clk);
            #1;
        end
    end

endmodule
